// File: rtl/fdd_sector_bridge_if.sv
// rtl/fdd_sector_bridge_if.sv - FDC request, buffer port, mount and SD handshake bundle
interface fdd_sector_bridge_if;
    logic        req_rd;
    logic        req_wr;
    logic [31:0] req_lba;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_din;
    logic        buf_we;
    logic [7:0]  buf_dout;
    logic        ready;
    logic        img_mounted;
    logic [31:0] img_size;
    logic        img_wp;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_dout;
    logic        sd_dout_strobe;
    logic [7:0]  sd_din;
    logic        sd_din_strobe;

    modport slave (
        input  req_rd, req_wr, req_lba, buf_addr, buf_din, buf_we,
        input  img_mounted, img_size, img_wp,
        input  sd_ack, sd_buff_addr, sd_dout, sd_dout_strobe, sd_din_strobe,
        output busy, done, err, buf_dout, ready, sd_lba, sd_rd, sd_wr, sd_din
    );

    modport master (
        output req_rd, req_wr, req_lba, buf_addr, buf_din, buf_we,
        output img_mounted, img_size, img_wp,
        output sd_ack, sd_buff_addr, sd_dout, sd_dout_strobe, sd_din_strobe,
        input  busy, done, err, buf_dout, ready, sd_lba, sd_rd, sd_wr, sd_din
    );
endinterface

// File: rtl/fdd_sector_bridge.sv
// rtl/fdd_sector_bridge.sv - one-sector buffer and SD read/write handshake engine for the FDC
module fdd_sector_bridge #(
    parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    fdd_sector_bridge_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, CHECK, RD_REQ, RD_XFER, WR_REQ, WR_XFER, FIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] lba_q, lba_d;
    logic        is_wr_q, is_wr_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [23:0] wd_q, wd_d;
    logic        ack_q, fall_q;
    logic        mnt_q, pend_q;
    logic [31:0] size_q;
    logic        wp_q, ready_q;
    logic [7:0]  dout_q, din_q;
    logic [7:0]  buf_mem [0:511];

    logic busy, range_bad, timeout, strobe, sd_wr_en;

    assign busy      = (state_q != IDLE) && (state_q != FIN);
    // Sector offset is 41 bits wide so huge LBAs cannot wrap into range.
    assign range_bad = {lba_q, 9'b0} >= {9'b0, size_q};
    assign timeout   = wd_q >= (TIMEOUT - 24'd1);
    assign strobe    = (state_q == RD_XFER) ? bus.sd_dout_strobe : bus.sd_din_strobe;
    assign sd_wr_en  = (state_q == RD_XFER) && bus.sd_dout_strobe;

    // Next-state and transaction bookkeeping.
    always_comb begin
        state_d = state_q;
        lba_d   = lba_q;
        is_wr_d = is_wr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (bus.req_rd || bus.req_wr) begin
                    state_d = CHECK;
                    lba_d   = bus.req_lba;
                    is_wr_d = !bus.req_rd;
                    err_d   = 1'b0;
                end
            end
            CHECK: begin
                if (!ready_q || range_bad || (is_wr_q && wp_q)) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_d = 10'd0;
                    wd_d  = 24'd0;
                    if (is_wr_q) begin
                        wr_d    = 1'b1;
                        state_d = WR_REQ;
                    end else begin
                        rd_d    = 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ, WR_REQ: begin
                wd_d = wd_q + 24'd1;
                if (timeout) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = FIN;
                end else if (bus.sd_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = (state_q == RD_REQ) ? RD_XFER : WR_XFER;
                end
            end
            RD_XFER, WR_XFER: begin
                wd_d = wd_q + 24'd1;
                if (strobe && (cnt_q != 10'h3FF))
                    cnt_d = cnt_q + 10'd1;
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else if (fall_q) begin
                    err_d   = (cnt_q != 10'd512);
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction state registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lba_q   <= 32'd0;
            is_wr_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 10'd0;
            wd_q    <= 24'd0;
            ack_q   <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lba_q   <= lba_d;
            is_wr_q <= is_wr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            ack_q   <= bus.sd_ack;
            fall_q  <= ack_q && !bus.sd_ack;
        end
    end

    // Mount edge is remembered and only applied while idle so transfers are never disturbed.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mnt_q   <= 1'b0;
            pend_q  <= 1'b0;
            size_q  <= 32'd0;
            wp_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            mnt_q <= bus.img_mounted;
            if (bus.img_mounted && !mnt_q)
                pend_q <= 1'b1;
            else if (state_q == IDLE)
                pend_q <= 1'b0;
            if ((state_q == IDLE) && pend_q) begin
                size_q  <= bus.img_size;
                wp_q    <= bus.img_wp;
                ready_q <= (bus.img_size != 32'd0);
            end
        end
    end

    // Sector RAM write port: SD fill has priority, FDC writes only while not busy.
    always_ff @(posedge clk_sys) begin
        if (sd_wr_en)
            buf_mem[bus.sd_buff_addr] <= bus.sd_dout;
        else if (bus.buf_we && !busy)
            buf_mem[bus.buf_addr] <= bus.buf_din;
    end

    // Registered read ports toward the FDC and the SD card.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= 8'd0;
            din_q  <= 8'd0;
        end else begin
            dout_q <= buf_mem[bus.buf_addr];
            din_q  <= buf_mem[bus.sd_buff_addr];
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = (state_q == FIN);
    assign bus.err      = err_q;
    assign bus.buf_dout = dout_q;
    assign bus.ready    = ready_q;
    assign bus.sd_lba   = lba_q;
    assign bus.sd_rd    = rd_q;
    assign bus.sd_wr    = wr_q;
    assign bus.sd_din   = din_q;
endmodule

// File: tb/tb_fdd_sector_bridge.sv
// tb/tb_fdd_sector_bridge.sv - randomized self-checking bench for fdd_sector_bridge
module tb_fdd_sector_bridge;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fdd_sector_bridge_if bus();
    fdd_sector_bridge_if bus_to();

    fdd_sector_bridge dut (.clk_sys(clk), .reset_n(reset_n), .bus(bus.slave));
    fdd_sector_bridge #(.TIMEOUT(24'd100)) dut_to (.clk_sys(clk), .reset_n(reset_n), .bus(bus_to.slave));

    int total = 0;
    int bad = 0;

    logic [7:0] model_buf [512];
    bit         model_ready = 0;
    longint     model_size = 0;
    bit         model_wp = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_reject(input longint lba, input bit wr);
        return !model_ready || (lba * 512 >= model_size) || (wr && model_wp);
    endfunction

    task automatic clear_inputs;
        bus.req_rd = 0; bus.req_wr = 0; bus.req_lba = 0;
        bus.buf_addr = 0; bus.buf_din = 0; bus.buf_we = 0;
        bus.img_mounted = 0; bus.img_size = 0; bus.img_wp = 0;
        bus.sd_ack = 0; bus.sd_buff_addr = 0; bus.sd_dout = 0;
        bus.sd_dout_strobe = 0; bus.sd_din_strobe = 0;
        bus_to.req_rd = 0; bus_to.req_wr = 0; bus_to.req_lba = 0;
        bus_to.buf_addr = 0; bus_to.buf_din = 0; bus_to.buf_we = 0;
        bus_to.img_mounted = 0; bus_to.img_size = 0; bus_to.img_wp = 0;
        bus_to.sd_ack = 0; bus_to.sd_buff_addr = 0; bus_to.sd_dout = 0;
        bus_to.sd_dout_strobe = 0; bus_to.sd_din_strobe = 0;
    endtask

    task automatic mount(input logic [31:0] size, input bit wp);
        bus.img_size = size;
        bus.img_wp = wp;
        bus.img_mounted = 1;
        tick;
        bus.img_mounted = 0;
        tick;
        tick;
        model_size = size;
        model_wp = wp;
        model_ready = (size != 0);
        total++;
        if (bus.ready !== model_ready) begin
            bad++;
            $display("FAIL mount_ready: got %b want %b", bus.ready, model_ready);
        end
    endtask

    // Pulses the request; returns in the cycle after the accepting edge.
    task automatic start_req(input bit rd, input bit wr, input logic [31:0] lba);
        bus.req_rd = rd;
        bus.req_wr = wr;
        bus.req_lba = lba;
        tick;
        bus.req_rd = 0;
        bus.req_wr = 0;
        total++;
        if (bus.busy !== 1'b1 || bus.sd_rd !== 1'b0 || bus.sd_wr !== 1'b0) begin
            bad++;
            $display("FAIL check_cycle: busy=%b sd_rd=%b sd_wr=%b want 1 0 0", bus.busy, bus.sd_rd, bus.sd_wr);
        end
    endtask

    task automatic expect_reject(input string name);
        tick;
        total++;
        if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.sd_rd !== 1'b0 || bus.sd_wr !== 1'b0) begin
            bad++;
            $display("FAIL %s: done=%b err=%b sd_rd=%b sd_wr=%b want 1 1 0 0", name, bus.done, bus.err, bus.sd_rd, bus.sd_wr);
        end
        tick;
        total++;
        if (bus.done !== 1'b0 || bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_hold: done=%b err=%b busy=%b want 0 1 0", name, bus.done, bus.err, bus.busy);
        end
    endtask

    // SD card side of a read: ack, stream n bytes, release ack, expect done. Leaves in the done cycle.
    task automatic serve_read(input string name, input int n, input bit pattern, input logic [31:0] lba);
        int waited = 0;
        logic [7:0] d;
        logic [8:0] a;
        while (bus.sd_rd !== 1'b1 && waited < 10) begin
            tick;
            waited++;
        end
        total++;
        if (bus.sd_rd !== 1'b1 || bus.sd_lba !== lba) begin
            bad++;
            $display("FAIL %s_req: sd_rd=%b sd_lba=%h want 1 %h", name, bus.sd_rd, bus.sd_lba, lba);
        end
        bus.sd_ack = 1;
        tick;
        total++;
        if (bus.sd_rd !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_ack_drop: sd_rd=%b busy=%b want 0 1", name, bus.sd_rd, bus.busy);
        end
        for (int i = 0; i < n; i++) begin
            a = 9'(i);
            d = pattern ? (a[7:0] ^ 8'hA5) : 8'($urandom);
            bus.sd_buff_addr = a;
            bus.sd_dout = d;
            bus.sd_dout_strobe = 1;
            model_buf[a] = d;
            tick;
        end
        bus.sd_dout_strobe = 0;
        bus.sd_ack = 0;
        tick;
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL %s_early_done: done=%b want 0", name, bus.done);
        end
        tick;
        total++;
        if (bus.done !== 1'b1 || bus.err !== (n != 512) || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_done: done=%b err=%b busy=%b want 1 %b 0", name, bus.done, bus.err, bus.busy, (n != 512));
        end
    endtask

    task automatic check_buf(input string name, input int samples);
        logic [8:0] a;
        int errs = 0;
        for (int i = 0; i < samples; i++) begin
            a = 9'($urandom);
            bus.buf_addr = a;
            tick;
            if (bus.buf_dout !== model_buf[a]) begin
                if (errs == 0)
                    $display("FAIL %s: addr %h got %h want %h", name, a, bus.buf_dout, model_buf[a]);
                errs++;
            end
        end
        total++;
        if (errs != 0) bad++;
    endtask

    task automatic test_reset;
        reset_n = 0;
        tick;
        tick;
        total++;
        if ({bus.busy, bus.done, bus.err, bus.ready, bus.sd_rd, bus.sd_wr, bus.sd_lba, bus.sd_din, bus.buf_dout} !== 53'd0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b ready=%b rd=%b wr=%b lba=%h din=%h dout=%h want all 0",
                     bus.busy, bus.done, bus.err, bus.ready, bus.sd_rd, bus.sd_wr, bus.sd_lba, bus.sd_din, bus.buf_dout);
        end
        reset_n = 1;
        tick;
    endtask

    task automatic test_mount_read;
        mount(32'd2048, 0);
        start_req(1, 0, 32'd3);
        serve_read("read_pattern", 512, 1, 32'd3);
        tick;
        bus.buf_addr = 9'h1FF;
        tick;
        total++;
        if (bus.buf_dout !== 8'h5A) begin
            bad++;
            $display("FAIL read_1ff: got %h want 5a", bus.buf_dout);
        end
        check_buf("read_pattern_buf", 20);
    endtask

    task automatic test_write;
        logic [8:0] a;
        int errs = 0;
        for (int i = 0; i < 512; i++) begin
            a = 9'(i);
            bus.buf_addr = a;
            bus.buf_din = a[7:0];
            bus.buf_we = 1;
            model_buf[a] = a[7:0];
            tick;
        end
        bus.buf_we = 0;
        start_req(0, 1, 32'd0);
        tick;
        total++;
        if (bus.sd_wr !== 1'b1 || bus.sd_rd !== 1'b0) begin
            bad++;
            $display("FAIL write_req: sd_wr=%b sd_rd=%b want 1 0", bus.sd_wr, bus.sd_rd);
        end
        bus.sd_ack = 1;
        tick;
        total++;
        if (bus.sd_wr !== 1'b0) begin
            bad++;
            $display("FAIL write_ack_drop: sd_wr=%b want 0", bus.sd_wr);
        end
        for (int i = 0; i < 512; i++) begin
            a = 9'(i);
            bus.sd_buff_addr = a;
            bus.sd_din_strobe = 1;
            tick;
            if (bus.sd_din !== model_buf[a]) begin
                if (errs == 0)
                    $display("FAIL write_data: addr %h got %h want %h", a, bus.sd_din, model_buf[a]);
                errs++;
            end
            if (a == 9'h07F) begin
                total++;
                if (bus.sd_din !== 8'h7F) begin
                    bad++;
                    $display("FAIL write_07f: got %h want 7f", bus.sd_din);
                end
            end
        end
        total++;
        if (errs != 0) bad++;
        bus.sd_din_strobe = 0;
        bus.sd_ack = 0;
        tick;
        tick;
        total++;
        if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL write_done: done=%b err=%b want 1 0", bus.done, bus.err);
        end
        tick;
    endtask

    task automatic test_out_of_range;
        mount(32'd2048, 0);
        start_req(1, 0, 32'd4);
        expect_reject("lba_range");
        mount(32'd2048, 1);
        start_req(0, 1, 32'd0);
        expect_reject("write_protect");
        mount(32'd2048, 0);
    endtask

    task automatic test_random_reads;
        int sectors, n;
        logic [31:0] size, lba;
        for (int it = 0; it < 6; it++) begin
            sectors = $urandom_range(1, 8);
            size = 32'(sectors * 512 - ($urandom_range(0, 1) ? $urandom_range(1, 511) : 0));
            mount(size, 0);
            lba = (it == 0) ? 32'h0080_0001 : 32'($urandom_range(0, sectors + 1));
            start_req(1, 0, lba);
            if (model_reject(longint'(lba), 0)) begin
                expect_reject("rand_reject");
            end else begin
                n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 700) : 512;
                serve_read("rand_read", n, 0, lba);
                tick;
                check_buf("rand_buf", 8);
            end
        end
        mount(32'd2048, 0);
    endtask

    task automatic test_short;
        start_req(1, 0, 32'd1);
        serve_read("short_read", 300, 0, 32'd1);
        tick;
        check_buf("short_buf", 10);
    endtask

    task automatic test_timeout;
        int c = 0;
        int rd_cycles = 0;
        bus_to.img_size = 32'd2048;
        bus_to.img_mounted = 1;
        tick;
        bus_to.img_mounted = 0;
        tick;
        tick;
        bus_to.req_rd = 1;
        bus_to.req_lba = 32'd0;
        tick;
        bus_to.req_rd = 0;
        while (bus_to.done !== 1'b1 && c < 300) begin
            if (bus_to.sd_rd === 1'b1) rd_cycles++;
            tick;
            c++;
        end
        // Accept edge, one CHECK edge, then TIMEOUT edges with sd_rd high before FIN.
        total++;
        if (c != 101 || rd_cycles != 100) begin
            bad++;
            $display("FAIL timeout_latency: cycles=%0d rd_cycles=%0d want 101 100", c, rd_cycles);
        end
        total++;
        if (bus_to.err !== 1'b1 || bus_to.sd_rd !== 1'b0 || bus_to.done !== 1'b1) begin
            bad++;
            $display("FAIL timeout_flags: done=%b err=%b sd_rd=%b want 1 1 0", bus_to.done, bus_to.err, bus_to.sd_rd);
        end
        tick;
    endtask

    task automatic test_mount_collision;
        start_req(1, 1, 32'd1);
        bus.buf_addr = 9'd400;
        bus.buf_din = ~model_buf[400];
        bus.buf_we = 1;
        tick;
        bus.buf_we = 0;
        total++;
        if (bus.sd_rd !== 1'b1 || bus.sd_wr !== 1'b0) begin
            bad++;
            $display("FAIL both_req: sd_rd=%b sd_wr=%b want 1 0", bus.sd_rd, bus.sd_wr);
        end
        serve_read("both_read", 300, 0, 32'd1);
        tick;
        bus.buf_addr = 9'd400;
        tick;
        total++;
        if (bus.buf_dout !== model_buf[400]) begin
            bad++;
            $display("FAIL busy_we: got %h want %h", bus.buf_dout, model_buf[400]);
        end

        start_req(1, 0, 32'd2);
        bus.img_size = 32'd0;
        bus.img_wp = 0;
        bus.img_mounted = 1;
        tick;
        bus.img_mounted = 0;
        serve_read("mount_during_read", 512, 0, 32'd2);
        total++;
        if (bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL mount_held: ready=%b want 1", bus.ready);
        end
        tick;
        tick;
        model_ready = 0;
        model_size = 0;
        total++;
        if (bus.ready !== 1'b0) begin
            bad++;
            $display("FAIL mount_applied: ready=%b want 0", bus.ready);
        end
        check_buf("mount_read_buf", 8);
        mount(32'd2048, 0);
    endtask

    task automatic test_reset_mid;
        start_req(1, 0, 32'd0);
        tick;
        bus.sd_ack = 1;
        tick;
        for (int i = 0; i < 100; i++) begin
            bus.sd_buff_addr = 9'(i);
            bus.sd_dout = 8'($urandom);
            bus.sd_dout_strobe = 1;
            model_buf[i] = bus.sd_dout;
            tick;
        end
        bus.sd_dout_strobe = 0;
        #1;
        reset_n = 0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.err, bus.ready, bus.sd_rd, bus.sd_wr, bus.sd_lba, bus.sd_din, bus.buf_dout} !== 53'd0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b err=%b ready=%b rd=%b wr=%b lba=%h din=%h dout=%h want all 0",
                     bus.busy, bus.done, bus.err, bus.ready, bus.sd_rd, bus.sd_wr, bus.sd_lba, bus.sd_din, bus.buf_dout);
        end
        bus.sd_ack = 0;
        model_ready = 0;
        tick;
        reset_n = 1;
        tick;
        start_req(1, 0, 32'd0);
        expect_reject("after_reset");
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_mount_read();
        test_write();
        test_out_of_range();
        test_random_reads();
        test_short();
        test_timeout();
        test_mount_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
